// File: rtl/hs_reg_pipeline_if.sv
// hs_reg_pipeline_if: handshaked input/output stream, flush and occupancy of a register pipeline
interface hs_reg_pipeline_if #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH = 3
);
    logic [DATA_WIDTH-1:0] din_data;
    logic din_vld;
    logic din_rd;
    logic [DATA_WIDTH-1:0] dout_data;
    logic dout_vld;
    logic dout_rd;
    logic flush;
    logic [$clog2(DEPTH+1)-1:0] occupancy;
    modport master (
        output din_data, din_vld, dout_rd, flush,
        input din_rd, dout_data, dout_vld, occupancy
    );
    modport slave (
        input din_data, din_vld, dout_rd, flush,
        output din_rd, dout_data, dout_vld, occupancy
    );
endinterface

// File: rtl/hs_reg_pipeline.sv
// hs_reg_pipeline: DEPTH-stage valid/ready register pipeline with bubble collapse, flush and occupancy
module hs_reg_pipeline #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH = 3,
    parameter logic [DATA_WIDTH-1:0] INIT_VAL = '0
) (
    input logic clk,
    input logic rst,
    hs_reg_pipeline_if.slave bus
);
    localparam int OW = $clog2(DEPTH+1);
    logic [DEPTH-1:0][DATA_WIDTH-1:0] data;
    logic [DEPTH:0][DATA_WIDTH-1:0] src_data;
    logic [DEPTH-1:0] vld, rd, nxt_vld;
    logic [DEPTH:0] src_vld;
    logic [OW-1:0] occ;
    assign src_data = {data, bus.din_data};
    assign src_vld = {vld, bus.din_vld};
    // stage i is ready unless it and every stage after it hold a word while the output stalls
    for (genvar i = 0; i < DEPTH; i++) begin : g_rd
        assign rd[i] = bus.dout_rd || !(&vld[DEPTH-1:i]);
    end
    always_comb begin
        nxt_vld = vld;
        for (int i = 0; i < DEPTH; i++) nxt_vld[i] = rd[i] ? src_vld[i] : vld[i];
        if (bus.flush) nxt_vld = '0;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            vld <= '0;
            data <= {DEPTH{INIT_VAL}};
            occ <= '0;
        end else begin
            vld <= nxt_vld;
            occ <= OW'($countones(nxt_vld));
            for (int i = 0; i < DEPTH; i++) if (rd[i] && !bus.flush) data[i] <= src_data[i];
        end
    end
    assign bus.din_rd = rd[0] && !bus.flush && !rst;
    assign bus.dout_data = data[DEPTH-1];
    assign bus.dout_vld = vld[DEPTH-1];
    assign bus.occupancy = occ;
endmodule

// File: doc/hs_reg_pipeline.md
# hs_reg_pipeline

Parametrised register pipeline with a valid/ready handshake. It is a chain of DEPTH data registers, each DATA_WIDTH bits wide, and each stage has its own valid flag. Bubbles collapse, so a stall at the output is absorbed by empty stages before it reaches the input. Use it wherever a plain D register stage would break a handshaked stream, for example for timing closure on long routes or to retime interface buses. It also provides a flush and an occupancy count.

## Interface
- DATA_WIDTH, 8, payload width in bits (>=1)
- DEPTH, 3, number of register stages (>=1)
- INIT_VAL, 0, reset value of every stage data register

- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, synchronous, active-high
- din_data  in  DATA_WIDTH  input payload
- din_vld  in  1  input word valid
- din_rd  out  1  pipeline can accept a word this cycle
- dout_data  out  DATA_WIDTH  payload of the last stage
- dout_vld  out  1  last stage holds a valid word
- dout_rd  in  1  downstream accepts the word this cycle
- flush  in  1  synchronous discard of all stored words
- occupancy  out  $clog2(DEPTH+1)  number of valid stages

## Operation
- Stages are numbered 0 (input side) to DEPTH-1 (output side).
- Each stage i has registers data_i and vld_i.
- dout_data is data_{DEPTH-1}; dout_vld is vld_{DEPTH-1}.
- Stage ready (combinational chain):
  - rd_DEPTH = dout_rd.
  - rd_i = !vld_i || rd_{i+1}.
  - din_rd = rd_0 && !flush && !rst.
- Stage 0 load, when rd_0 is 1: vld_0 <= din_vld && din_rd, and data_0 <= din_data.
- Stage i>0 load, when rd_i is 1: vld_i <= vld_{i-1}, and data_i <= data_{i-1}.
- When rd_i is 0, stage i holds its data and valid.
- A data register loads only when its stage loads. The payload of an empty stage is stale and holds its last value; dout_data is undefined-by-contract while dout_vld=0.
- Transfers:
  - Input transfer: din_vld && din_rd.
  - Output transfer: dout_vld && dout_rd.
  - Words leave in arrival order; none is duplicated or dropped, except by flush.
- Occupancy is the population count of vld_0..vld_{DEPTH-1}, registered. It equals the number of valid flags after the edge.
- Flush:
  - Next edge: all vld_i <= 0. Data registers are unchanged.
  - din_rd=0 in that cycle, so no input is accepted.
  - If dout_vld && dout_rd in the flush cycle, that word counts as delivered. All other stored words are discarded.
- rst has priority over flush.
- rst:
  - Next edge: all vld_i <= 0, all data_i <= INIT_VAL, occupancy <= 0.
  - din_rd=0 while rst=1.

## Timing
- Reset values:
  - dout_vld = 0.
  - dout_data = INIT_VAL.
  - occupancy = 0.
  - din_rd = 1 in the first cycle after rst deasserts (pipeline empty).
- Latency: a word accepted at edge N into an empty, non-stalled pipeline shows dout_vld=1 after edge N+DEPTH-1. It is visible DEPTH cycles after din_vld was sampled.
- Throughput: one word per cycle sustained while dout_rd=1.
- Full: all DEPTH stages valid and dout_rd=0 gives din_rd=0.
- With DEPTH=1, full and dout_rd=1: the simultaneous read and write gives a 1-cycle replacement. occupancy stays 1.
- Stall collapse: dout_rd=0 with bubbles present. Upstream words keep advancing into empty stages, and din_rd stays 1 until every stage is valid.
- din_rd depends combinationally on dout_rd through the full ready chain. This is the accepted critical path. No combinational path exists from din_* to dout_*.
- din_vld must not depend on din_rd. Once asserted, din_data is held stable until accepted (AXI-Stream-style rule).

## Test plan
- Reset and idle:
  - Stimulus: DATA_WIDTH=8, DEPTH=3, INIT_VAL=0xA5. Assert rst for 2 cycles, then release.
  - Required: dout_vld=0, dout_data=0xA5, occupancy=0, din_rd=1.
- Latency and streaming:
  - Stimulus: dout_rd=1. Send 0x01,0x02,0x03,0x04 on consecutive cycles.
  - Required: dout_vld rises 3 cycles after 0x01 is accepted. Words come out in order 0x01..0x04, back to back. occupancy peaks at 3.
- Backpressure and bubble collapse:
  - Stimulus: dout_rd=0. Send 0x10 and 0x11 with a 2-cycle gap between them.
  - Required: both words collapse to the output end. occupancy=2 and din_rd=1. A third word 0x12 gives occupancy=3 and din_rd=0.
  - Then raise dout_rd: 0x10, 0x11, 0x12 come out on 3 consecutive cycles.
- Full with simultaneous read/write:
  - Stimulus: pipeline full, with dout_rd=1 and din_vld=1 held.
  - Required: din_rd=1 every cycle, occupancy stays 3, and there is no loss or duplication over 20 random words checked against a scoreboard.
- Flush:
  - Stimulus: occupancy=3 with 0x20,0x21,0x22 stored. Pulse flush while dout_rd=1 and din_vld=1 carries 0x23.
  - Required: 0x20 is delivered. 0x21, 0x22 and 0x23 are discarded (din_rd=0 that cycle). Next cycle occupancy=0 and dout_vld=0.
- Reset mid-stream and random stress:
  - Stimulus: assert rst while occupancy=2.
  - Required: next cycle occupancy=0, dout_data=0xA5, din_rd=0 during rst.
  - Then run 10k cycles of random din_vld, dout_rd and flush at 1%, for DEPTH 1, 2 and 5. Required: scoreboard matches and occupancy is always consistent.
